// File: rtl/wash_cycle_sequencer_pkg.sv
// Shared types and default phase durations for the wash cycle sequencer.
// Build with SEQ_DOOR_PAUSE_EN defined to make SW[0] (door open) pause cycles.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WASH,
    RINSE,
    SPIN,
    DRY,
    FINISH,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    NONE,
    NORMAL,
    DELICATE,
    HEAVY,
    DRYER
  } mode_t;

  localparam int unsigned TICK_DIV_D = 100_000_000;
  localparam int unsigned T_FILL_D   = 5;
  localparam int unsigned T_WASH_D   = 10;
  localparam int unsigned T_RINSE_D  = 5;
  localparam int unsigned T_SPIN_D   = 6;
  localparam int unsigned T_DRY_D    = 20;

  // Highest-numbered selector wins when several switches are up.
  function automatic mode_t decode_mode(
    input logic [4:1] sw
  );
    mode_t m;
    m = NONE;
    priority case (1'b1)
      sw[4]:   m = DRYER;
      sw[3]:   m = HEAVY;
      sw[2]:   m = DELICATE;
      sw[1]:   m = NORMAL;
      default: m = NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wash_cycle_sequencer_if.sv
// Panel/payment-side signal bundle of the wash cycle sequencer.
// master drives the switches and amount; slave is the sequencer.
interface wash_cycle_sequencer_if;
  logic       BTNR;
  logic [5:0] SW;
  logic [3:0] count;
  logic       bin;
  logic [2:0] phase;
  logic [7:0] secs_left;
  logic       hot;
  logic       busy;
  logic       done;

  modport master (
    output BTNR, SW, count,
    input  bin, phase, secs_left,
    input  hot, busy, done
  );

  modport slave (
    input  BTNR, SW, count,
    output bin, phase, secs_left,
    output hot, busy, done
  );
endinterface

// File: rtl/wash_cycle_sequencer_sec_tick.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled,
// pulses tick on the last count and wraps.
module sec_tick #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST =
    W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Runs one paid wash or dry cycle and returns a borrow pulse on completion.
// Optional: SEQ_DOOR_PAUSE_EN makes SW[0] freeze a running cycle.
module wash_cycle_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_D,
  parameter int unsigned T_FILL   = T_FILL_D,
  parameter int unsigned T_WASH   = T_WASH_D,
  parameter int unsigned T_RINSE  = T_RINSE_D,
  parameter int unsigned T_SPIN   = T_SPIN_D,
  parameter int unsigned T_DRY    = T_DRY_D
) (
  input logic CLK100MHZ,
  input logic BTNC,
  wash_cycle_sequencer_if.slave io
);

  state_t     state, state_n;
  mode_t      mode_q, mode_n, mode_sw;
  logic [7:0] secs_q, secs_n;
  logic       hot_q, hot_n;
  logic       bin_q;
  logic       btnr_q;
  logic       running, door, tick, clr;
  logic       start_ok;

`ifdef SEQ_DOOR_PAUSE_EN
  assign door = io.SW[0];
`else
  assign door = 1'b0;
`endif

  function automatic logic [7:0] dur(
    input state_t s,
    input mode_t  m
  );
    logic [7:0] d;
    d = 8'd0;
    case (s)
      FILL:  d = 8'(T_FILL);
      WASH:
        if (m == DELICATE)
          d = 8'(T_WASH / 2);
        else if (m == HEAVY)
          d = 8'(T_WASH + T_WASH / 2);
        else
          d = 8'(T_WASH);
      RINSE: d = 8'(T_RINSE);
      SPIN:
        d = (m == DELICATE) ?
          8'(T_SPIN / 2) : 8'(T_SPIN);
      DRY:   d = 8'(T_DRY);
      default: d = 8'd0;
    endcase
    return d;
  endfunction

  function automatic state_t after(
    input state_t s,
    input mode_t  m
  );
    state_t n;
    n = FINISH;
    case (s)
      FILL:  n = WASH;
      WASH:  n = (m == DELICATE) ? SPIN : RINSE;
      RINSE: n = SPIN;
      default: n = FINISH;
    endcase
    return n;
  endfunction

  assign running = state inside
    {FILL, WASH, RINSE, SPIN, DRY};
  assign mode_sw = decode_mode(io.SW[4:1]);

  assign start_ok =
    io.BTNR && !btnr_q && !door &&
    (mode_sw != NONE) &&
    (io.count != 4'd0) &&
    ((mode_sw != DRYER) || (io.count == 4'd2));

  sec_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (CLK100MHZ),
    .rst  (BTNC),
    .en   (running && !door),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    secs_n  = secs_q;
    mode_n  = mode_q;
    hot_n   = hot_q;
    clr     = 1'b0;
    unique case (state)
      IDLE:
        if (start_ok) begin
          mode_n  = mode_sw;
          hot_n   = (io.count == 4'd2);
          clr     = 1'b1;
          state_n = (mode_sw == DRYER) ?
            DRY : FILL;
          secs_n  = dur(state_n, mode_sw);
        end
      FILL, WASH, RINSE, SPIN, DRY:
        if (tick) begin
          if (secs_q > 8'd1) begin
            secs_n = secs_q - 8'd1;
          end else begin
            state_n = after(state, mode_q);
            secs_n  = dur(state_n, mode_q);
          end
        end
      FINISH: begin
        state_n = DONE;
        secs_n  = 8'd0;
      end
      DONE:
        if (io.SW[4:1] == 4'b0000)
          state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      state  <= IDLE;
      mode_q <= NONE;
      secs_q <= 8'd0;
      hot_q  <= 1'b0;
      bin_q  <= 1'b0;
      btnr_q <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      secs_q <= secs_n;
      hot_q  <= hot_n;
      bin_q  <= (state_n == FINISH);
      btnr_q <= io.BTNR;
    end
  end

  assign io.phase     = state;
  assign io.secs_left = secs_q;
  assign io.hot       = hot_q;
  assign io.bin       = bin_q;
  assign io.busy      = running;
  assign io.done      = (state == DONE);

endmodule
